// File: rtl/busarb_pkg.sv
// busarb_pkg: shared types and helpers
// for the round-robin bus arbiter.
package busarb_pkg;

  typedef enum logic [1:0] {
    RUN,
    WAIT_BND,
    FREEZE,
    SETTLE
  } arb_state_t;

  localparam int CTRL_W = 3;

  function automatic int grant_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/busarbiter_rr_pick.sv
// rr_next_pick: next requester after the
// current grant, by rotate then priority encode.
module rr_next_pick #(
  parameter int N  = 2,
  parameter int GW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [GW-1:0] grant,
  output logic [GW-1:0] nxt,
  output logic          found
);

  logic [N-1:1]  rot;
  logic [GW-1:0] idx;

  always_comb begin
    rot   = '0;
    idx   = '0;
    nxt   = grant;
    found = 1'b0;
    // rot[k] is the request of core grant+k
    for (int k = 1; k < N; k++) begin
      idx    = GW'((int'(grant) + k) % N);
      rot[k] = req[idx];
    end
    for (int k = N - 1; k >= 1; k--) begin
      if (rot[k]) begin
        found = 1'b1;
        nxt   = GW'((int'(grant) + k) % N);
      end
    end
  end

endmodule

// File: rtl/busarbiter_rr.sv
// busarbiter_rr: round-robin time-slicing
// arbiter for the shared memory channel.
module busarbiter_rr
  import busarb_pkg::*;
#(
  parameter int NCORES = 2,
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int GW     = grant_w(NCORES)
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     init_done,
  input  logic [7:0]               max_cnt,
  input  logic                     sys_busy,
  input  logic [NCORES-1:0]        req,
  input  logic [NCORES-1:0]        lock,
  input  logic [NCORES-1:0]        at_bnd,
  input  logic [NCORES*AW-1:0]     m_addr,
  input  logic [NCORES*DW-1:0]     m_wdata,
  input  logic [NCORES-1:0]        m_we,
  input  logic [NCORES-1:0]        m_le,
  input  logic [NCORES*CTRL_W-1:0] m_ctrl,
  output logic [NCORES*DW-1:0]     m_rdata,
  output logic [NCORES-1:0]        m_busy,
  output logic [AW-1:0]            s_addr,
  output logic [DW-1:0]            s_wdata,
  output logic                     s_we,
  output logic                     s_le,
  output logic [CTRL_W-1:0]        s_ctrl,
  input  logic [DW-1:0]            s_rdata,
  output logic [GW-1:0]            grant,
  output logic [NCORES-1:0]        grant_oh,
  output logic [31:0]              switches
);

  arb_state_t    state;
  logic [7:0]    cnt;
  logic [GW-1:0] nxt;
  logic [GW-1:0] nxt_q;
  logic          found;
  logic          hold;
  logic          gate;
  logic          eff_busy;
  logic          bnd_ok;

  rr_next_pick #(
    .N  (NCORES),
    .GW (GW)
  ) u_pick (
    .req   (req),
    .grant (grant),
    .nxt   (nxt),
    .found (found)
  );

  assign hold     = (state == FREEZE) || (state == SETTLE);
  assign gate     = RST | hold;
  assign eff_busy = hold | sys_busy;
  assign bnd_ok   = at_bnd[grant] & ~lock[grant] & ~sys_busy;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= RUN;
      cnt      <= '0;
      grant    <= '0;
      grant_oh <= NCORES'(1);
      nxt_q    <= '0;
      switches <= '0;
    end else if (!init_done) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      unique case (state)
        RUN: begin
          if (cnt < max_cnt) cnt <= cnt + 8'd1;
          else state <= WAIT_BND;
        end
        WAIT_BND: begin
          if (bnd_ok) begin
            cnt <= '0;
            if (found) begin
              nxt_q <= nxt;
              state <= FREEZE;
            end else begin
              state <= RUN;
            end
          end
        end
        FREEZE: begin
          grant    <= nxt_q;
          grant_oh <= NCORES'(1) << nxt_q;
          switches <= switches + 32'd1;
          state    <= SETTLE;
        end
        SETTLE: begin
          cnt   <= '0;
          state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

  always_comb begin
    m_rdata = '0;
    m_busy  = '1;
    for (int i = 0; i < NCORES; i++) begin
      if (grant_oh[i]) begin
        m_rdata[i*DW +: DW] = s_rdata;
        if (!RST) m_busy[i] = eff_busy;
      end
    end
  end

  assign s_addr  = m_addr[int'(grant)*AW +: AW];
  assign s_wdata = m_wdata[int'(grant)*DW +: DW];
  assign s_ctrl  = m_ctrl[int'(grant)*CTRL_W +: CTRL_W];
  assign s_we    = m_we[grant] & ~gate;
  assign s_le    = m_le[grant] & ~gate;

endmodule

// File: tb/tb_busarbiter_rr.sv
// tb_busarbiter_rr: scoreboard bench for
// the round-robin bus arbiter.
module tb_busarbiter_rr;
  import busarb_pkg::*;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int GW = 2;

  logic            CLK = 1'b0;
  logic            RST = 1'b1;
  logic            init_done = 1'b0;
  logic [7:0]      max_cnt = '0;
  logic            sys_busy = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N-1:0]    lock = '0;
  logic [N-1:0]    at_bnd = '0;
  logic [N*AW-1:0] m_addr = '0;
  logic [N*DW-1:0] m_wdata = '0;
  logic [N-1:0]    m_we = '0;
  logic [N-1:0]    m_le = '0;
  logic [N*3-1:0]  m_ctrl = '0;
  logic [N*DW-1:0] m_rdata;
  logic [N-1:0]    m_busy;
  logic [AW-1:0]   s_addr;
  logic [DW-1:0]   s_wdata;
  logic            s_we;
  logic            s_le;
  logic [2:0]      s_ctrl;
  logic [DW-1:0]   s_rdata = '0;
  logic [GW-1:0]   grant;
  logic [N-1:0]    grant_oh;
  logic [31:0]     switches;

  busarbiter_rr #(
    .NCORES (N),
    .AW     (AW),
    .DW     (DW)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .init_done (init_done),
    .max_cnt   (max_cnt),
    .sys_busy  (sys_busy),
    .req       (req),
    .lock      (lock),
    .at_bnd    (at_bnd),
    .m_addr    (m_addr),
    .m_wdata   (m_wdata),
    .m_we      (m_we),
    .m_le      (m_le),
    .m_ctrl    (m_ctrl),
    .m_rdata   (m_rdata),
    .m_busy    (m_busy),
    .s_addr    (s_addr),
    .s_wdata   (s_wdata),
    .s_we      (s_we),
    .s_le      (s_le),
    .s_ctrl    (s_ctrl),
    .s_rdata   (s_rdata),
    .grant     (grant),
    .grant_oh  (grant_oh),
    .switches  (switches)
  );

  always #5 CLK = ~CLK;

  int          n_chk = 0;
  int          n_fail = 0;
  int          ms = 0;
  int          mcnt = 0;
  int          mg = 0;
  int          mn = 0;
  logic [31:0] msw = '0;
  logic [63:0] sbq[$];
  bit          rnd_rdata = 1'b0;
  bit          seen12 = 1'b0;

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive_data();
    m_addr  = {$urandom, $urandom, $urandom, $urandom};
    m_wdata = {$urandom, $urandom, $urandom, $urandom};
    m_we    = 4'($urandom);
    m_le    = 4'($urandom);
    m_ctrl  = 12'($urandom);
    s_rdata = rnd_rdata ? $urandom : 32'hDEADBEEF;
  endtask

  task automatic cyc();
    logic [N-1:0]    eb;
    logic [N*DW-1:0] er;
    logic [63:0]     e;
    logic            hold;
    bit              fnd;
    drive_data();
    #1;
    hold = (ms == 2) || (ms == 3);
    eb = '1;
    er = '0;
    if (!RST) eb[mg] = hold | sys_busy;
    er[mg*DW +: DW] = s_rdata;
    chk("m_busy", m_busy, eb);
    chk("s_we", s_we, (RST || hold) ? 1'b0 : m_we[mg]);
    chk("s_le", s_le, (RST || hold) ? 1'b0 : m_le[mg]);
    chk("s_addr", s_addr, m_addr[mg*AW +: AW]);
    chk("s_wdata", s_wdata, m_wdata[mg*DW +: DW]);
    chk("s_ctrl", s_ctrl, m_ctrl[mg*3 +: 3]);
    chk("m_rdata", m_rdata, er);
    if (grant == 2'd1 || grant == 2'd2) seen12 = 1'b1;
    if (RST) begin
      ms = 0; mcnt = 0; mg = 0; msw = '0;
    end else if (!init_done) begin
      ms = 0; mcnt = 0;
    end else begin
      case (ms)
        0: if (mcnt < int'(max_cnt)) mcnt++; else ms = 1;
        1: if (at_bnd[mg] && !lock[mg] && !sys_busy) begin
          fnd = 1'b0;
          for (int j = 1; j < N; j++)
            if (!fnd && req[(mg + j) % N]) begin
              fnd = 1'b1;
              mn = (mg + j) % N;
            end
          mcnt = 0;
          ms = fnd ? 2 : 0;
        end
        2: begin mg = mn; msw = msw + 32'd1; ms = 3; end
        default: begin ms = 0; mcnt = 0; end
      endcase
    end
    sbq.push_back({32'(mg), msw});
    @(posedge CLK);
    #1;
    e = sbq.pop_front();
    chk("grant", grant, e[63:32]);
    chk("grant_oh", grant_oh, 4'b0001 << e[63:32]);
    chk("switches", switches, e[31:0]);
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  task automatic do_reset();
    RST = 1'b1;
    run(1);
    RST = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge CLK);
    #1;
    run(2);
    chk("rst_grant", grant, 0);
    chk("rst_oh", grant_oh, 4'b0001);
    chk("rst_sw", switches, 0);
    chk("rst_busy", m_busy, 4'hF);

    RST = 1'b0;
    init_done = 1'b1;
    max_cnt = 8'd3;
    req = 4'b0011;
    at_bnd = '1;
    run(5);
    chk("tc_hold", grant, 0);
    run(1);
    chk("tc_g1", grant, 1);
    chk("tc_sw1", switches, 1);
    run(15);
    chk("tc_g3", grant, 1);
    chk("tc_sw3", switches, 3);

    do_reset();
    max_cnt = 8'd2;
    req = 4'b1001;
    seen12 = 1'b0;
    run(4);
    chk("idle_hold", grant, 0);
    run(1);
    chk("idle_g3", grant, 3);
    run(10);
    chk("idle_seen12", seen12, 0);

    do_reset();
    max_cnt = 8'd1;
    req = 4'b0011;
    lock = 4'b0001;
    run(22);
    chk("lock_g", grant, 0);
    chk("lock_sw", switches, 0);
    lock = '0;
    run(1);
    chk("lock_g_t1", grant, 0);
    run(1);
    chk("lock_g_t2", grant, 1);
    chk("lock_sw_t2", switches, 1);
    run(1);
    chk("lock_busy1", m_busy[1], 0);

    do_reset();
    req = 4'b0001;
    max_cnt = 8'd0;
    repeat (15) begin
      sys_busy = 1'($urandom);
      run(1);
    end
    sys_busy = 1'b0;
    chk("sole_sw", switches, 0);
    chk("sole_g", grant, 0);

    do_reset();
    max_cnt = 8'd0;
    req = 4'b0100;
    run(3);
    chk("rms_g2", grant, 2);
    RST = 1'b1;
    #1;
    chk("rms_rst_busy", m_busy, 4'hF);
    run(1);
    chk("rms_g0", grant, 0);
    chk("rms_sw", switches, 0);
    RST = 1'b0;
    #1;
    chk("rms_run_busy", m_busy, 4'b1110);

    rnd_rdata = 1'b1;
    do_reset();
    repeat (400) begin
      req = 4'($urandom);
      lock = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0;
      at_bnd = 4'($urandom);
      sys_busy = ($urandom_range(0, 3) == 0);
      max_cnt = 8'($urandom_range(0, 3));
      init_done = ($urandom_range(0, 15) != 0);
      RST = ($urandom_range(0, 99) == 0);
      run(1);
    end
    RST = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/busarbiter_rr.md
# busarbiter_rr

Parametrised round-robin successor to the two-core bus arbiter. It time-slices one shared memory/DRAM/MMIO channel among `NCORES` cores and picks the next core only among those that are requesting, so idle cores are skipped. A per-core lock holds the bus through atomic or multi-beat operations, and the quantum length is set at run time. It sits between the core array and the shared memory subsystem.

## Interface
Parameters:
- `NCORES`, 2: number of cores; any value ≥ 2, power of two not required.
- `AW`, 32: address width.
- `DW`, 32: data width.
- `GW`, `$clog2(NCORES)`: grant index width (derived).

Ports (all flattened per-core vectors are core-major: core i occupies slice `[i*W +: W]`):
- `CLK` in 1: clock; the only clock in the block.
- `RST` in 1: synchronous reset, active-high.
- `init_done` in 1: arbitration frozen while low.
- `max_cnt` in 8: quantum length; RUN lasts `max_cnt+1` cycles.
- `sys_busy` in 1: OR of downstream busies (DRAM busy, UART not ready, data busy).
- `req` in NCORES: core i wants the bus.
- `lock` in NCORES: core i must not be preempted.
- `at_bnd` in NCORES: core i is at an instruction boundary (decode state).
- `m_addr` in NCORES*AW; `m_wdata` in NCORES*DW; `m_we` in NCORES; `m_le` in NCORES; `m_ctrl` in NCORES*3: per-core requests.
- `m_rdata` out NCORES*DW: granted core gets `s_rdata`; all others get 0.
- `m_busy` out NCORES: granted core gets the effective busy; all others get 1.
- `s_addr` out AW; `s_wdata` out DW; `s_we` out 1; `s_le` out 1; `s_ctrl` out 3: signals of the granted core.
- `s_rdata` in DW: shared read data.
- `grant` out GW: index of the granted core.
- `grant_oh` out NCORES: one-hot form of `grant`.
- `switches` out 32: count of completed grant changes (wraps).

## Operation
The arbiter is a state machine with four states.

- **RUN**
  - If `cnt < max_cnt`, increment `cnt`; otherwise go to WAIT_BND.
- **WAIT_BND**
  - Leave only when the granted core has `at_bnd=1`, `lock=0` and `sys_busy=0` in the same cycle.
  - Compute `nxt` as the first index j in `grant+1 … grant+NCORES-1` (mod NCORES) with `req[j]=1`.
  - If a `nxt` exists, go to FREEZE.
  - If none exists, go to RUN with `cnt=0`; `grant` and `switches` are unchanged.
- **FREEZE** (1 cycle)
  - The old core's busy is forced to 1.
  - `grant <= nxt`, latched at WAIT_BND exit.
  - `switches++`.
  - Go to SETTLE.
- **SETTLE** (1 cycle)
  - The new core's busy is forced to 1.
  - Go to RUN with `cnt=0`.

Shared-side outputs and busy:
- Effective busy is 1 in FREEZE and SETTLE, and `sys_busy` otherwise.
- In FREEZE and SETTLE, `s_we` and `s_le` are forced to 0; address, data and ctrl still pass through.
- With `init_done=0`: state stays RUN, `cnt` holds at 0, `grant` holds, and the normal mux applies.
- `req` of the granted core is ignored for preemption. An idle core is still preempted at a boundary if another core requests.

## Timing
Reset values:
- State RUN, `cnt=0`, `grant=0`, `grant_oh=1`, `switches=0`.
- While `RST=1`, `m_busy` is all ones and `s_we=s_le=0`.
- Reset asserted mid-switch returns to RUN with core 0 on the next edge; no partial grant survives.

Latency and switch timing:
- The mux path (`m_*` to `s_*`, `s_rdata` to `m_rdata`) is combinational, with zero latency.
- If the WAIT_BND exit condition holds at edge t, FREEZE occupies cycle t+1.
- The new `grant` is visible in cycle t+2 (SETTLE); the new core sees busy=0 at t+3, provided `sys_busy=0`.

Boundary conditions:
- `max_cnt=0` gives a 1-cycle RUN.
- A `max_cnt` change takes effect on the next RUN-state comparison.
- A lock that rises during WAIT_BND stalls the switch indefinitely; there is no timeout.
- `nxt` wraps modulo NCORES. Example with NCORES=3, grant=2, req=3'b011: nxt=0.
- `switches` wraps 0xFFFFFFFF→0.

## Structure
- Package `busarb_pkg`:
  - state enum RUN/WAIT_BND/FREEZE/SETTLE;
  - ctrl width constant 3;
  - function `grant_w(n)`.
- Sub-module `rr_next_pick`:
  - purely combinational;
  - inputs: `req`, current `grant`;
  - outputs: `nxt` and `found`;
  - implemented with a rotate-then-priority-encode scheme.
- Top level holds the FSM, the `cnt` and `switches` counters, and the output muxes.

## Test plan
- **Two-core basic:** NCORES=2, `max_cnt=3`, both `req=1`, `at_bnd` always 1 → grant toggles every 7 cycles (4 RUN + WAIT_BND + FREEZE + SETTLE); `switches` increments each toggle.
- **Idle skip:** NCORES=4, grant=0, `req=4'b1001`, quantum expires at a boundary → grant=3; cores 1 and 2 are never granted; `m_busy[1]=m_busy[2]=1` throughout.
- **Lock hold:** `lock[0]=1` for 20 cycles past quantum expiry → grant stays 0 and `switches` stays unchanged; switch completes 3 cycles after `lock[0]` drops.
- **Sole requester:** `req=4'b0001`, grant=0 → FREEZE/SETTLE never entered, `switches=0`, `m_busy[0]` tracks `sys_busy` every cycle.
- **Switch masking:** issue `m_we[0]=1` during FREEZE → `s_we=0`; `s_rdata=0xDEADBEEF` in RUN → only the granted core's `m_rdata` equals 0xDEADBEEF, all others 0.
- **Reset mid-switch:** `RST=1` during SETTLE with grant=2 → next cycle grant=0, state RUN, `m_busy` all ones while `RST` is high.
